nram_writer: RTL and testbench
==============================

# nram_writer

Write-side controller for the `NRAM` register bank. Accepts data words on a valid/ready stream and writes them round-robin into the bank's slots. It drives the bank's data bus and one-hot write-enable bus, tracks slot occupancy, and frees slots when the read side releases them. Sits between the upstream producer and `NRAM`; the `NMux` read path consumes the slots it fills.

## Interface
- `DATA_W`, 8, data word width; equals bank register width
- `SLOTS`, 2, number of bank registers; power of two, 2..16
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_in_data`  in  DATA_W  write word
- `io_in_valid`  in  1  producer has a word
- `io_in_ready`  out  1  controller accepts this cycle
- `io_Dbus`  out  DATA_W  registered data to bank
- `io_ENbus`  out  SLOTS  registered one-hot write strobe to bank
- `io_valid_mask`  out  SLOTS  bit i = slot i holds unread data landed in the bank
- `io_release`  in  SLOTS  reader frees slot i (per-bit, single-cycle pulses, any combination)
- `io_count`  out  clog2(SLOTS)+1  number of occupied slots (busy, including pending)

## Operation
- State per slot: `busy` (accepted, not released) and `valid` (data landed in bank).
- Write pointer `ptr`, width clog2(SLOTS), wraps SLOTS-1 -> 0.
- `io_in_ready` = reset deasserted AND NOT `busy[ptr]`.
- Accept = `io_in_valid & io_in_ready`. On accept: `busy[ptr]` set, `io_Dbus` <= `io_in_data`, `io_ENbus` <= one-hot(`ptr`), `ptr` increments.
- Without accept, `io_ENbus` <= 0. `io_Dbus` holds its last value.
- `valid[i]` is set on the edge where `io_ENbus[i]` is high, which is also the edge where the bank captures.
- Release bit i clears `busy[i]` and `valid[i]` only if `valid[i]` = 1. A release of a slot that is pending (busy, not valid) or free is ignored.
- `io_count` = popcount(`busy`). An accept and a release in the same cycle leave the count unchanged.
- Strobe FSM per slot, two states: FREE and OCCUPIED.
  - FREE -> OCCUPIED on accept.
  - OCCUPIED -> FREE on a valid release.

## Timing
- Accept at edge N. `io_ENbus`/`io_Dbus` are valid during cycle N+1. The bank captures and `io_valid_mask` rises at edge N+1.
- Back-to-back throughput is one word per cycle while free slots exist.
- Full: all `busy` set, `io_in_ready` = 0, `io_count` = SLOTS.
- A release at edge N on the slot at `ptr` gives `io_in_ready` = 1 in cycle N+1. Ready is never combinational from `io_release`.
- A simultaneous accept on slot A and release of slot B≠A both take effect.
- Reset asserted, including mid-write:
  - Asynchronously clears `ptr`, `busy`, `valid`, `io_ENbus`, `io_Dbus`, and `io_count` to 0. A pending strobe is dropped.
  - `io_in_ready` = 0 while reset is asserted and 1 on the first cycle after deassertion.

## Configuration
- Macro `NRAM_WRITER_OVERWRITE_EN`.
- **Defined:**
  - `io_in_ready` is held 1 outside reset.
  - An accept into a busy slot overwrites it: strobe issued, `valid` stays/becomes 1.
  - Extra output `io_ovf_count`, 8 bits, increments (saturating at 255) per overwrite and resets to 0.
- **Undefined:** backpressure behaviour as above; `io_ovf_count` port is absent.

## Structure
- Package `nram_pkg`:
  - `NRAM_DATA_W` and `NRAM_SLOTS` defaults.
  - `nram_ptr_t`, a pointer typedef sized clog2(NRAM_SLOTS).
  - `onehot()` function.
  - `popcount()` function.
- Sub-module `nram_slot_tracker`: `busy`/`valid` vectors, release filtering, and popcount. The top level holds the pointer, handshake, and output registers.

## Test plan
- **Reset then single write:** deassert reset, send 0xA5 valid one cycle.
  - Cycle +1: `io_ENbus` = 01, `io_Dbus` = 0xA5.
  - Edge +1: `io_valid_mask` = 01, `io_count` = 1.
- **Fill to full:** SLOTS=2, send 0x11, 0x22 back-to-back with valid held high.
  - Strobes 01 then 10.
  - `io_in_ready` = 0 on the third cycle, `io_count` = 2, third word stalls.
- **Release wrap-around:** from full, pulse `io_release` = 01.
  - Next cycle `io_in_ready` = 1 and `ptr` = 0.
  - Stalled word 0x33 is written with `io_ENbus` = 01.
- **Early release ignored:** accept 0x44 into slot 0 and assert `io_release[0]` on the strobe cycle. Slot 0 stays busy, `io_count` = 1, then `io_valid_mask` = 01.
- **Mid-write reset:** accept 0x55, assert reset in the strobe cycle.
  - `io_ENbus` drops to 0 immediately; bank slot is unchanged.
  - All masks and `io_count` read 0.
- **Overwrite build:** with `NRAM_WRITER_OVERWRITE_EN`, write 3 words into SLOTS=2 without release.
  - Third strobe = 01, `io_ovf_count` = 1, `io_count` = 2.

Source files
------------

// File: rtl/nram_pkg.sv
// Shared types, defaults and helpers for the NRAM write-side controller.
package nram_pkg;

  localparam int NRAM_DATA_W = 8;
  localparam int NRAM_SLOTS  = 2;
  localparam int NRAM_PTR_W  = (NRAM_SLOTS > 1) ? $clog2(NRAM_SLOTS) : 1;

  typedef logic [NRAM_PTR_W-1:0] nram_ptr_t;

  typedef enum logic {
    SLOT_FREE     = 1'b0,
    SLOT_OCCUPIED = 1'b1
  } slot_state_e;

  // Helpers are sized for the largest supported bank (16 slots); callers cast down.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nram_slot_tracker.sv
// Per-slot occupancy FSMs, landed-data flags, release filtering and occupancy count.
//
// state         | meaning
// SLOT_FREE     | slot may accept a new word
// SLOT_OCCUPIED | word accepted, not yet released by the reader
module nram_slot_tracker
  import nram_pkg::*;
#(
  parameter int SLOTS = NRAM_SLOTS,
  localparam int CNT_W = $clog2(SLOTS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SLOTS-1:0] set_busy,
  input  logic [SLOTS-1:0] strobe,
  input  logic [SLOTS-1:0] release_req,
  output logic [SLOTS-1:0] busy,
  output logic [SLOTS-1:0] valid,
  output logic [CNT_W-1:0] count
);

  logic [SLOTS-1:0] rel_eff;

  // A release only counts for data already in the bank; a strobe landing on the
  // same edge carries newer data, so the release is dropped for that slot.
  assign rel_eff = release_req & valid & ~strobe;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_state_e st_q;
    slot_state_e st_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= SLOT_FREE;
      else        st_q <= st_d;
    end

    always_comb begin
      st_d = st_q;
      case (st_q)
        SLOT_FREE:     if (set_busy[i]) st_d = SLOT_OCCUPIED;
        SLOT_OCCUPIED: if (rel_eff[i] && !set_busy[i]) st_d = SLOT_FREE;
        default:       st_d = SLOT_FREE;
      endcase
    end

    assign busy[i] = (st_q == SLOT_OCCUPIED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid <= '0;
    else        valid <= (valid & ~rel_eff) | strobe;
  end

  assign count = CNT_W'(popcount(16'(busy)));

endmodule

// File: rtl/nram_writer.sv
// Write-side controller for the NRAM bank: round-robin slot writes with registered strobes.
// Optional NRAM_WRITER_OVERWRITE_EN: never backpressure, overwrite busy slots, count overwrites.
module nram_writer
  import nram_pkg::*;
#(
  parameter int DATA_W = NRAM_DATA_W,
  parameter int SLOTS  = NRAM_SLOTS,
  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CNT_W = $clog2(SLOTS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  output logic [DATA_W-1:0] io_Dbus,
  output logic [SLOTS-1:0]  io_ENbus,
  output logic [SLOTS-1:0]  io_valid_mask,
  input  logic [SLOTS-1:0]  io_release,
  output logic [CNT_W-1:0]  io_count
`ifdef NRAM_WRITER_OVERWRITE_EN
  ,
  output logic [7:0]        io_ovf_count
`endif
);

  logic [PTR_W-1:0] ptr;
  logic [SLOTS-1:0] ptr_oh;
  logic [SLOTS-1:0] busy;
  logic [SLOTS-1:0] set_busy;
  logic             busy_at_ptr;
  logic             accept;

  assign ptr_oh      = SLOTS'(onehot(4'(ptr)));
  assign busy_at_ptr = |(busy & ptr_oh);

`ifdef NRAM_WRITER_OVERWRITE_EN
  assign io_in_ready = reset;
`else
  assign io_in_ready = reset & ~busy_at_ptr;
`endif

  assign accept   = io_in_valid & io_in_ready;
  assign set_busy = accept ? ptr_oh : '0;

  // Pointer wraps for free since SLOTS is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      io_Dbus  <= '0;
      io_ENbus <= '0;
    end else if (accept) begin
      ptr      <= ptr + PTR_W'(1);
      io_Dbus  <= io_in_data;
      io_ENbus <= ptr_oh;
    end else begin
      io_ENbus <= '0;
    end
  end

`ifdef NRAM_WRITER_OVERWRITE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           io_ovf_count <= '0;
    else if (accept && busy_at_ptr && io_ovf_count != 8'hFF) io_ovf_count <= io_ovf_count + 8'd1;
  end
`endif

  nram_slot_tracker #(
    .SLOTS (SLOTS)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .set_busy    (set_busy),
    .strobe      (io_ENbus),
    .release_req (io_release),
    .busy        (busy),
    .valid       (io_valid_mask),
    .count       (io_count)
  );

endmodule

// File: tb/tb_nram_writer.sv
// Directed and randomized bench for nram_writer against a slot-level reference model.
module tb_nram_writer;

  localparam int SLOTS  = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(SLOTS) + 1;
`ifdef NRAM_WRITER_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_valid;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_Dbus;
  logic [SLOTS-1:0]  io_ENbus;
  logic [SLOTS-1:0]  io_valid_mask;
  logic [SLOTS-1:0]  io_release;
  logic [CNT_W-1:0]  io_count;
`ifdef NRAM_WRITER_OVERWRITE_EN
  logic [7:0]        io_ovf_count;
`endif

  nram_writer #(.DATA_W(DATA_W), .SLOTS(SLOTS)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_data    (io_in_data),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_Dbus       (io_Dbus),
    .io_ENbus      (io_ENbus),
    .io_valid_mask (io_valid_mask),
    .io_release    (io_release),
    .io_count      (io_count)
`ifdef NRAM_WRITER_OVERWRITE_EN
    ,
    .io_ovf_count  (io_ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Bank stand-in: captures the data bus wherever the strobe is high.
  logic [DATA_W-1:0] bank [SLOTS];
  initial for (int i = 0; i < SLOTS; i++) bank[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < SLOTS; i++)
      if (io_ENbus[i]) bank[i] <= io_Dbus;

  int checks = 0;
  int errors = 0;

  // Reference model state, in slot terms
  bit                busy_m  [SLOTS];
  bit                valid_m [SLOTS];
  logic [DATA_W-1:0] bank_m  [SLOTS];
  int                ptr_m;
  int                en_m;      // slot being strobed this cycle, -1 if none
  logic [DATA_W-1:0] d_m;
  int                ovf_m;

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      busy_m[i]  = 1'b0;
      valid_m[i] = 1'b0;
    end
    ptr_m = 0;
    en_m  = -1;
    d_m   = '0;
    ovf_m = 0;
  endtask

  function automatic bit ready_m();
    return (reset === 1'b1) && (OVW || !busy_m[ptr_m]);
  endfunction

  function automatic int count_m();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) n += int'(busy_m[i]);
    return n;
  endfunction

  task automatic model_edge();
    bit acc;
    bit was_busy;
    bit rel_eff [SLOTS];
    acc      = io_in_valid && ready_m();
    was_busy = busy_m[ptr_m];
    if (en_m >= 0) bank_m[en_m] = d_m;
    for (int i = 0; i < SLOTS; i++)
      rel_eff[i] = io_release[i] && valid_m[i] && (en_m != i);
    for (int i = 0; i < SLOTS; i++) begin
      valid_m[i] = (valid_m[i] && !rel_eff[i]) || (en_m == i);
      busy_m[i]  = (busy_m[i] && !rel_eff[i]) || (acc && ptr_m == i);
    end
    if (acc) begin
      if (was_busy && ovf_m < 255) ovf_m++;
      en_m  = ptr_m;
      d_m   = io_in_data;
      ptr_m = (ptr_m + 1) % SLOTS;
    end else begin
      en_m = -1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] mask_m;
    mask_m = '0;
    for (int i = 0; i < SLOTS; i++) mask_m[i] = valid_m[i];
    check("enbus", 32'(io_ENbus), (en_m >= 0) ? (32'd1 << en_m) : 32'd0);
    check("dbus", 32'(io_Dbus), 32'(d_m));
    check("valid_mask", 32'(io_valid_mask), mask_m);
    check("count", 32'(io_count), 32'(count_m()));
    check("ready", 32'(io_in_ready), 32'(ready_m()));
    for (int i = 0; i < SLOTS; i++) check("bank", 32'(bank[i]), 32'(bank_m[i]));
`ifdef NRAM_WRITER_OVERWRITE_EN
    check("ovf_count", 32'(io_ovf_count), 32'(ovf_m));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (reset === 1'b1) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check_all();
    step();
    step();
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(io_in_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) bank_m[i] = '0;
    model_clear();
    reset       = 1'b0;
    io_in_data  = '0;
    io_in_valid = 1'b0;
    io_release  = '0;
    #2;
    check_all();
    step();
    step();
    check("reset_ready", 32'(io_in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(io_in_ready), 32'd1);

`ifndef NRAM_WRITER_OVERWRITE_EN
    // single write
    io_in_valid = 1'b1; io_in_data = 8'hA5;
    step();
    check("single_en", 32'(io_ENbus), 32'h1);
    check("single_d", 32'(io_Dbus), 32'hA5);
    io_in_valid = 1'b0;
    step();
    check("single_mask", 32'(io_valid_mask), 32'h1);
    check("single_count", 32'(io_count), 32'd1);

    // fill to full, then release wrap-around
    do_reset();
    io_in_valid = 1'b1; io_in_data = 8'h11;
    step();
    check("fill_en0", 32'(io_ENbus), 32'h1);
    io_in_data = 8'h22;
    step();
    check("fill_en1", 32'(io_ENbus), 32'h2);
    check("fill_ready", 32'(io_in_ready), 32'd0);
    check("fill_count", 32'(io_count), 32'd2);
    io_in_data = 8'h33;
    step();
    check("stall_en", 32'(io_ENbus), 32'h0);
    check("stall_d", 32'(io_Dbus), 32'h22);
    io_release = 2'b01;
    step();
    io_release = '0;
    check("wrap_ready", 32'(io_in_ready), 32'd1);
    step();
    check("wrap_en", 32'(io_ENbus), 32'h1);
    check("wrap_d", 32'(io_Dbus), 32'h33);
    io_in_valid = 1'b0;
    step();

    // early release on the strobe cycle is ignored
    do_reset();
    io_in_valid = 1'b1; io_in_data = 8'h44;
    step();
    io_in_valid = 1'b0; io_release = 2'b01;
    step();
    io_release = '0;
    check("early_count", 32'(io_count), 32'd1);
    check("early_mask", 32'(io_valid_mask), 32'h1);
    step();

    // reset in the strobe cycle drops the write
    do_reset();
    io_in_valid = 1'b1; io_in_data = 8'h55;
    step();
    io_in_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    #1;
    check("midrst_en", 32'(io_ENbus), 32'h0);
    check("midrst_count", 32'(io_count), 32'd0);
    check("midrst_mask", 32'(io_valid_mask), 32'h0);
    step();
    check("midrst_bank", 32'(bank[0]), 32'h44);
    reset = 1'b1;
    #1;
`else
    // overwrite: three words into two slots
    io_in_valid = 1'b1;
    io_in_data = 8'h01; step();
    io_in_data = 8'h02; step();
    io_in_data = 8'h03; step();
    check("ovw_en", 32'(io_ENbus), 32'h1);
    check("ovw_ovf", 32'(io_ovf_count), 32'd1);
    check("ovw_count", 32'(io_count), 32'd2);
    io_in_valid = 1'b0;
    step();
    do_reset();
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      io_in_valid = ($urandom_range(3) != 0);
      io_in_data  = DATA_W'($urandom);
      io_release  = ($urandom_range(2) == 0) ? SLOTS'($urandom) : '0;
      if (n == 200) do_reset();
      step();
    end
    io_in_valid = 1'b0;
    io_release  = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
